// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle for 32 cycles. Sign fix-up happens on the edge that enters DONE.
// Divide-by-zero and signed overflow are resolved straight from IDLE.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  localparam int W = XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [4:0]     cnt_q;
  logic [2:0]     op_q;
  logic [2*W-1:0] acc_q;   // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]   b_q;     // multiplicand or divisor magnitude
  logic           na_q;    // operand a is signed-negative
  logic           nb_q;    // operand b is signed-negative
  logic [W-1:0]   result_q;
  logic           done_q;
  logic           busy_q;

  // Operand decode on the raw inputs, used only when accepting in IDLE.
  logic           a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic           div0, ovf, special;
  logic [W-1:0]   spec_res;

  // Sign treatment per funct3 and early-out detection.
  always_comb begin
    a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & src_a[W-1];
    b_neg    = b_sgn & src_b[W-1];
    mag_a    = a_neg ? (~src_a + 1'b1) : src_a;
    mag_b    = b_neg ? (~src_b + 1'b1) : src_b;
    div0     = funct3[2] & (src_b == '0);
    ovf      = funct3[2] & ~funct3[0] & (src_a == {1'b1, {(W-1){1'b0}}}) & (src_b == '1);
    special  = div0 | ovf;
    if (div0)
      spec_res = funct3[1] ? src_a : '1;
    else
      spec_res = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // One iteration step of either algorithm, plus final sign fix-up.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_mul, acc_div, acc_d;
  logic [W:0]     rem_sh;
  logic           qbit;
  logic [W-1:0]   rem_sub;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot_s, rem_s, calc_res;

  always_comb begin
    // Shift-add: conditionally add multiplicand to the upper half, then shift right.
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_mul = {mul_sum, acc_q[W-1:1]};
    // Restoring divide: shift in next dividend bit, subtract if it fits.
    rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    qbit    = (rem_sh >= {1'b0, b_q});
    rem_sub = rem_sh[W-1:0] - b_q;   // exact whenever qbit=1, since result < divisor
    acc_div = {(qbit ? rem_sub : rem_sh[W-1:0]), acc_q[W-2:0], qbit};
    acc_d   = op_q[2] ? acc_div : acc_mul;
    // Sign correction applied to the post-iteration value.
    prod_s  = (na_q ^ nb_q) ? (~acc_d + 1'b1) : acc_d;
    quot_s  = (na_q ^ nb_q) ? (~acc_d[W-1:0] + 1'b1) : acc_d[W-1:0];
    rem_s   = na_q ? (~acc_d[2*W-1:W] + 1'b1) : acc_d[2*W-1:W];
    if (!op_q[2])
      calc_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    else
      calc_res = op_q[1] ? rem_s : quot_s;
  end

  // Control FSM with registered done/busy; flush squashes without touching result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      na_q     <= 1'b0;
      nb_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= funct3;
            cnt_q  <= '0;
            acc_q  <= {{W{1'b0}}, mag_a};
            b_q    <= mag_b;
            na_q   <= a_neg;
            nb_q   <= b_neg;
            busy_q <= 1'b1;
            if (special) begin
              state_q  <= S_DONE;
              result_q <= spec_res;
              done_q   <= 1'b1;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= S_DONE;
            result_q <= calc_res;
            done_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle combinationally, then all of CALC.
  always_comb begin
    stall = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_CALC);
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU. It consumes the instruction's funct3 and the forwarded operands and produces a 32-bit result after a fixed multi-cycle latency. While it computes, it holds the pipeline via a stall request. Single-cycle ALU operations continue to use the ALU control path unchanged.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported
- `clk`  in  1  clock; all state changes on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  execute-stage instruction is an M-extension op and is valid
- `flush`  in  1  squash any in-flight operation (branch mispredict or trap)
- `funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src_a`  in  XLEN  rs1 operand (multiplicand / dividend)
- `src_b`  in  XLEN  rs2 operand (multiplier / divisor)
- `result`  out  XLEN  operation result; valid while `done`=1, held afterwards
- `done`  out  1  one-cycle pulse; `result` valid
- `busy`  out  1  state is not IDLE
- `stall`  out  1  stall request to hazard unit

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start`=1, `flush`=0:
  - Latch `funct3` and operands, clear iteration counter.
  - Go to CALC, except for special cases, which go directly to DONE.
- Special cases (detected in IDLE from the raw operands):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `src_a`.
  - Signed overflow (DIV/REM with `src_a`=0x80000000, `src_b`=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Multiply (CALC):
  - Radix-2 shift-add on operand magnitudes, one bit per cycle, 64-bit product.
  - Sign rules: MUL and MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - Final product is negated if exactly one operand is signed-negative.
  - MUL returns bits [31:0]; the other multiplies return bits [63:32].
- Divide (CALC):
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign is the XOR of the operand signs (signed ops only).
  - Remainder takes the dividend's sign.
  - Truncation toward zero.
- CALC runs exactly 32 iterations (counter 0..31); after the counter-31 iteration the state goes to DONE.
- DONE:
  - `done`=1 and `result` is driven for exactly one cycle.
  - Next state is IDLE.
  - `start` in DONE is ignored; the pipeline advances that cycle, and a new op is accepted only from IDLE.
- `start` while in CALC or DONE is ignored; no queuing.
- `flush` (any state):
  - Next state is IDLE and the counter clears.
  - `done` is not asserted for the squashed op.
  - `result` retains its previous value.
  - `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- Asynchronous reset:
  - State IDLE, counter 0, `result` 0x00000000.
  - `done`, `busy`, `stall` all 0.
  - Reset mid-CALC abandons the op with no `done`.

## Timing
- Accepting edge E0 (IDLE, `start`=1).
- Normal op:
  - CALC iterations occur on edges E1..E32.
  - `done`=1 in the cycle between E32 and E33; the pipeline captures `result` at E33.
  - Total of 33 cycles of `stall` (see below).
- Special case: `done`=1 in the cycle between E0 and E1.
- `stall` = (IDLE & `start` & ~`flush`) | CALC. It is combinational from `start`, low in DONE.
- `busy` = CALC | DONE, registered.
- `result` changes only on the edge entering DONE, or on reset.

## Test plan
- MUL: `src_a`=7, `src_b`=0xFFFFFFFD (-3) -> `result`=0xFFFFFFEB.
  - `done` pulse exactly 33 cycles after the accepting cycle.
  - `stall` high for those 33 cycles.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide, 0xFFFFFFF9 (-7) by 2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 1.
- Special cases, each with `done` in the cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Flush at iteration 10:
  - State IDLE on the next edge; no `done`; `result` unchanged.
  - A following MULHU 3x5 -> 0 completes normally.
  - Repeat the scenario with `reset_n` pulsed low mid-CALC instead of `flush`: all outputs go to 0 immediately.
- Handshake corners (`done` count must equal accepted ops):
  - `start` held high continuously: one op per 34 cycles (accept, CALC, DONE, IDLE re-accept).
  - `start`+`flush` together in IDLE: nothing accepted, `stall`=0.
